// File: rtl/disp_pkg.sv
// Shared encodings for the 7-segment scan controller: FSM states,
// active-low segment patterns and the all-off constants.
package disp_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Index n holds the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = SEG_TABLE[i_nibble];

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexes four snapshotted hex digits onto a common-anode display,
// advancing one digit per 120 Hz strobe edge with a dark gap before each digit.
//
// state   | meaning
// S_BLANK | all anodes off, blank counter running (or idle until first strobe)
// S_SHOW  | selected digit lit from the frame snapshot
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int P_BLANK_CYCLES = 1000,
    parameter int P_SYNC_STAGES  = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_120Hz,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    input  logic        i_lz_en,
    output logic [3:0]  o_anodes,
    output logic [6:0]  o_segments,
    output logic        o_dp,
    output logic [1:0]  o_digit_idx
);

    localparam int BLANK_EFF = (P_BLANK_CYCLES < 1) ? 1 : P_BLANK_CYCLES;
    localparam int CW        = (BLANK_EFF > 1) ? $clog2(BLANK_EFF) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BLANK_EFF - 1);

    logic [P_SYNC_STAGES-1:0] sync_q;
    logic                     edge_q;
    logic                     rise_p;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [1:0]    idx_d;
    logic          started_q;
    logic [3:0]    anodes_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [15:0]   snap_digits_q;
    logic [3:0]    snap_dp_q;
    logic          snap_lz_q;

    logic [3:0]    nibble;
    logic          lz_blank;
    logic [6:0]    dec_seg;
    logic [3:0]    an_show;
    logic [6:0]    seg_show;
    logic          dp_show;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], i_clk_120Hz};
            edge_q <= sync_q[P_SYNC_STAGES-1];
        end
    end

    assign rise_p = sync_q[P_SYNC_STAGES-1] & ~edge_q;
    assign idx_d  = idx_q + 2'd1;

    always_comb begin
        nibble   = snap_digits_q[3:0];
        lz_blank = 1'b0;
        case (idx_q)
            2'd0: nibble = snap_digits_q[3:0];
            2'd1: begin
                nibble   = snap_digits_q[7:4];
                lz_blank = (snap_digits_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble   = snap_digits_q[11:8];
                lz_blank = (snap_digits_q[15:8] == 8'h00);
            end
            default: begin
                nibble   = snap_digits_q[15:12];
                lz_blank = (snap_digits_q[15:12] == 4'h0);
            end
        endcase
    end

    hex_to_7seg u_dec (
        .i_nibble   (nibble),
        .o_segments (dec_seg)
    );

    assign an_show  = ~(4'b0001 << idx_q);
    assign seg_show = (snap_lz_q && lz_blank) ? SEG_OFF : dec_seg;
    assign dp_show  = ~snap_dp_q[idx_q];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= S_BLANK;
            cnt_q         <= '0;
            idx_q         <= 2'd3;
            started_q     <= 1'b0;
            anodes_q      <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
        end else if (rise_p) begin
            idx_q     <= idx_d;
            state_q   <= S_BLANK;
            cnt_q     <= CNT_LOAD;
            started_q <= 1'b1;
            anodes_q  <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            // Frame boundary: latch a coherent copy of all digit inputs.
            if (idx_q == 2'd3) begin
                snap_digits_q <= i_digits;
                snap_dp_q     <= i_dp;
                snap_lz_q     <= i_lz_en;
            end
        end else if (state_q == S_BLANK) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (started_q) begin
                state_q  <= S_SHOW;
                anodes_q <= an_show;
                seg_q    <= seg_show;
                dp_q     <= dp_show;
            end
        end
    end

    assign o_anodes    = anodes_q;
    assign o_segments  = seg_q;
    assign o_dp        = dp_q;
    assign o_digit_idx = idx_q;

endmodule
